// File: rtl/exec_wr_tracker.sv
// Per-wavefront pending-write tracker for EXEC/VCC/M0/SCC. Issue uses query_stall to hold
// back readers of those registers until every in-flight write has been reported complete.
module exec_wr_tracker #(
  parameter int NUM_WF = 40,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_en,
  input  logic [5:0]        alloc_wfid,
  input  logic [3:0]        alloc_dst,
  input  logic              issue_salu_wr_exec_en,
  input  logic              issue_salu_wr_vcc_en,
  input  logic              issue_salu_wr_m0_en,
  input  logic              issue_salu_wr_scc_en,
  input  logic [5:0]        issue_salu_wr_vcc_wfid,
  input  logic              issue_valu_wr_vcc_en,
  input  logic [5:0]        issue_valu_wr_vcc_wfid,
  input  logic              halt_en,
  input  logic [5:0]        halt_wfid,
  input  logic [5:0]        query_wfid,
  input  logic [3:0]        query_src,
  output logic              query_stall,
  output logic [NUM_WF-1:0] wf_pending,
  output logic              err_overflow,
  output logic              err_underflow
);

  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // Counter index k: 0=exec, 1=vcc, 2=m0, 3=scc (same order as the masks).
  logic [NUM_WF-1:0][3:0][CNT_W-1:0] cnt_r;
  logic [NUM_WF-1:0][3:0][CNT_W-1:0] cnt_nxt_s;
  logic                              ovf_s;
  logic                              unf_s;

  // Next-state of every counter: net inc/dec with clamping, halt overrides everything.
  always_comb begin
    int  inc_v;
    int  dec_v;
    int  sum_v;
    logic salu_hit;
    logic valu_hit;
    logic halt_hit;
    cnt_nxt_s = cnt_r;
    ovf_s     = 1'b0;
    unf_s     = 1'b0;
    inc_v     = 0;
    dec_v     = 0;
    sum_v     = 0;
    salu_hit  = 1'b0;
    valu_hit  = 1'b0;
    halt_hit  = 1'b0;
    for (int w = 0; w < NUM_WF; w++) begin
      salu_hit = (issue_salu_wr_vcc_wfid == 6'(w));
      valu_hit = issue_valu_wr_vcc_en && (issue_valu_wr_vcc_wfid == 6'(w));
      halt_hit = halt_en && (halt_wfid == 6'(w));
      for (int k = 0; k < 4; k++) begin
        inc_v = int'(alloc_en && (alloc_wfid == 6'(w)) && alloc_dst[k]);
        case (k)
          0:       dec_v = int'(salu_hit && issue_salu_wr_exec_en);
          1:       dec_v = int'(salu_hit && issue_salu_wr_vcc_en) + int'(valu_hit);
          2:       dec_v = int'(salu_hit && issue_salu_wr_m0_en);
          3:       dec_v = int'(salu_hit && issue_salu_wr_scc_en);
          default: dec_v = 0;
        endcase
        sum_v = int'(cnt_r[w][k]) + inc_v - dec_v;
        if (halt_hit) begin
          cnt_nxt_s[w][k] = {CNT_W{1'b0}};
        end else if (sum_v < 0) begin
          cnt_nxt_s[w][k] = {CNT_W{1'b0}};
          unf_s           = 1'b1;
        end else if (sum_v > CNT_MAX) begin
          cnt_nxt_s[w][k] = CNT_W'(CNT_MAX);
          ovf_s           = 1'b1;
        end else begin
          cnt_nxt_s[w][k] = CNT_W'(sum_v);
        end
      end
    end
  end

  // Counter array and sticky error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r         <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      cnt_r         <= cnt_nxt_s;
      err_overflow  <= err_overflow | ovf_s;
      err_underflow <= err_underflow | unf_s;
    end
  end

  // Hazard query and pending summary, both from registered counters only.
  always_comb begin
    query_stall = 1'b0;
    wf_pending  = '0;
    for (int w = 0; w < NUM_WF; w++) begin
      wf_pending[w] = |cnt_r[w];
      for (int k = 0; k < 4; k++) begin
        query_stall = query_stall |
                      ((query_wfid == 6'(w)) && query_src[k] && (cnt_r[w][k] != {CNT_W{1'b0}}));
      end
    end
  end

endmodule
